// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg: shared CPU definitions for the load/store sequencer.
// Holds the opcode constants, the 2-bit FSM state encoding and the
// default bus widths.
package mem_access_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [4:0] OP_LOAD  = 5'b00101;
  localparam logic [4:0] OP_STORE = 5'b00110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: control-unit, memory and register-file signals
// of the load/store sequencer.
//   slave  : the sequencer (takes start/decode fields and memAck/memRData,
//            drives memReq/memWe/memAddr/memWData, Rin/regSel/rData,
//            stall/done/error)
//   master : the surrounding CPU / memory model
interface mem_access_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              isStore;
  logic [2:0]        regSelIn;
  logic [ADDR_W-1:0] addrIn;
  logic [DATA_W-1:0] wDataIn;
  logic              memAck;
  logic [DATA_W-1:0] memRData;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic              Rin;
  logic [2:0]        regSel;
  logic [DATA_W-1:0] rData;
  logic              stall;
  logic              done;
  logic              error;

  modport slave (
    input  start, isStore, regSelIn, addrIn, wDataIn, memAck, memRData,
    output memReq, memWe, memAddr, memWData, Rin, regSel, rData,
           stall, done, error
  );

  modport master (
    output start, isStore, regSelIn, addrIn, wDataIn, memAck, memRData,
    input  memReq, memWe, memAddr, memWData, Rin, regSel, rData,
           stall, done, error
  );
endinterface

// File: rtl/mem_access_sequencer_timeout_counter.sv
// mem_timeout_counter: counts memory-request cycles without acknowledge.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : hold count at zero (asserted outside the request state)
//   enable   : count this cycle (request pending, no ack)
//   limit    : number of un-acked cycles allowed
//   expired  : this enabled cycle is the limit-th one
module mem_timeout_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + ONE;
  end

  // Flags the cycle whose increment would reach the limit, so exactly
  // 'limit' request cycles elapse before the abort.
  assign expired = enable && (cnt == limit - ONE);
endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: multi-cycle load/store sequencer between the
// instruction control unit and the data-memory port.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : mem_access_sequencer_if.slave (decode inputs, memory handshake,
//          register-file write-back, stall/done/error)
// Optional macro MEM_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES
// un-acked cycles, pulsing error together with done; otherwise error is 0.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_access_sequencer_if.slave        bus
);
  if (TIMEOUT_CYCLES < 1) begin : g_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state_q, state_d;
  logic              store_q;
  logic [2:0]        reg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timed_out;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic expired;
  logic err_q;

  mem_timeout_counter #(.W(CW)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ST_REQ),
    .enable ((state_q == ST_REQ) && !bus.memAck),
    .limit  (CW'(TIMEOUT_CYCLES)),
    .expired(expired)
  );
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    timed_out = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_REQ;
      ST_REQ: begin
        // Ack takes priority over an expiring timeout in the same cycle.
        if (bus.memAck)   state_d = store_q ? ST_DONE : ST_WB;
        else if (expired) begin
          state_d   = ST_DONE;
          timed_out = 1'b1;
        end
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_q <= 1'b0;
      reg_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.start) begin
        store_q <= bus.isStore;
        reg_q   <= bus.regSelIn;
        addr_q  <= bus.addrIn;
        wdata_q <= bus.wDataIn;
      end
      if (state_q == ST_REQ && bus.memAck && !store_q)
        rdata_q <= bus.memRData;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= timed_out;
  end
  assign bus.error = (state_q == ST_DONE) && err_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.memReq   = (state_q == ST_REQ);
  assign bus.memWe    = (state_q == ST_REQ) && store_q;
  assign bus.memAddr  = addr_q;
  assign bus.memWData = wdata_q;
  assign bus.Rin      = (state_q == ST_WB);
  assign bus.regSel   = reg_q;
  assign bus.rData    = rdata_q;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.stall    = ((state_q == ST_IDLE) && bus.start) ||
                        (state_q == ST_REQ) || (state_q == ST_WB);

  logic unused_ok;
  assign unused_ok = timed_out;
endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_access_sequencer #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       st, ist;
    logic [2:0] rs;
    logic [7:0] ad, wd;
    logic       ack;
    logic [7:0] rd;
    logic       e_req, e_we, e_rin, e_done, e_stall;
    logic [7:0] e_addr, e_wd;
    logic [2:0] e_rs;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, ist, input logic [2:0] rs, input logic [7:0] ad, wd,
                     input logic ack, input logic [7:0] rd,
                     input logic q, we, rin, dn, sl, input logic [7:0] ea, ew,
                     input logic [2:0] ers, input logic [7:0] erd);
    vec_t v;
    v.st = st; v.ist = ist; v.rs = rs; v.ad = ad; v.wd = wd; v.ack = ack; v.rd = rd;
    v.e_req = q; v.e_we = we; v.e_rin = rin; v.e_done = dn; v.e_stall = sl;
    v.e_addr = ea; v.e_wd = ew; v.e_rs = ers; v.e_rd = erd;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, ist, input logic [2:0] rs, input logic [7:0] ad, wd,
                       input logic ack, input logic [7:0] rd);
    bus.start = st; bus.isStore = ist; bus.regSelIn = rs; bus.addrIn = ad;
    bus.wDataIn = wd; bus.memAck = ack; bus.memRData = rd;
  endtask

  initial begin
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    //  st ist rs  ad     wd     ack rd     | req we rin dn stall addr  wd     rs  rd
    // load, ack on cycle 3
    add(1, 0, 5, 8'h3A, 8'h00, 0, 8'h00,   0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   1, 0, 0, 0, 1, 8'h3A, 8'h00, 5, 8'h00);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   1, 0, 0, 0, 1, 8'h3A, 8'h00, 5, 8'h00);
    add(0, 0, 0, 8'h00, 8'h00, 1, 8'hC7,   1, 0, 0, 0, 1, 8'h3A, 8'h00, 5, 8'h00);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   0, 0, 1, 0, 1, 8'h3A, 8'h00, 5, 8'hC7);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   0, 0, 0, 1, 0, 8'h3A, 8'h00, 5, 8'hC7);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   0, 0, 0, 0, 0, 8'h3A, 8'h00, 5, 8'hC7);
    // store, immediate ack
    add(1, 1, 2, 8'hFF, 8'h55, 0, 8'h00,   0, 0, 0, 0, 1, 8'h3A, 8'h00, 5, 8'hC7);
    add(0, 0, 0, 8'h00, 8'h00, 1, 8'h11,   1, 1, 0, 0, 1, 8'hFF, 8'h55, 2, 8'hC7);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   0, 0, 0, 1, 0, 8'hFF, 8'h55, 2, 8'hC7);
    // stray ack in IDLE
    add(0, 0, 0, 8'h00, 8'h00, 1, 8'h99,   0, 0, 0, 0, 0, 8'hFF, 8'h55, 2, 8'hC7);
    // load with ignored start/ack in REQ, WB, DONE
    add(1, 0, 1, 8'h10, 8'h00, 0, 8'h00,   0, 0, 0, 0, 1, 8'hFF, 8'h55, 2, 8'hC7);
    add(1, 1, 7, 8'h99, 8'h77, 0, 8'h00,   1, 0, 0, 0, 1, 8'h10, 8'h00, 1, 8'hC7);
    add(0, 0, 0, 8'h00, 8'h00, 1, 8'h00,   1, 0, 0, 0, 1, 8'h10, 8'h00, 1, 8'hC7);
    add(1, 0, 6, 8'hAA, 8'h00, 1, 8'hEE,   0, 0, 1, 0, 1, 8'h10, 8'h00, 1, 8'h00);
    add(1, 0, 4, 8'hBB, 8'h00, 1, 8'hEE,   0, 0, 0, 1, 0, 8'h10, 8'h00, 1, 8'h00);
    // back-to-back: accepted one cycle after DONE
    add(1, 0, 3, 8'h00, 8'h00, 0, 8'h00,   0, 0, 0, 0, 1, 8'h10, 8'h00, 1, 8'h00);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   1, 0, 0, 0, 1, 8'h00, 8'h00, 3, 8'h00);
    add(0, 0, 0, 8'h00, 8'h00, 1, 8'hFF,   1, 0, 0, 0, 1, 8'h00, 8'h00, 3, 8'h00);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   0, 0, 1, 0, 1, 8'h00, 8'h00, 3, 8'hFF);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   0, 0, 0, 1, 0, 8'h00, 8'h00, 3, 8'hFF);
    add(0, 0, 0, 8'h00, 8'h00, 0, 8'h00,   0, 0, 0, 0, 0, 8'h00, 8'h00, 3, 8'hFF);

    // reset state
    #2;
    chk("rst_memReq", 16'(bus.memReq), 16'h0);
    chk("rst_stall", 16'(bus.stall), 16'h0);
    chk("rst_memAddr", 16'(bus.memAddr), 16'h0);
    chk("rst_rData", 16'(bus.rData), 16'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      @(negedge clk);
      drive(v.st, v.ist, v.rs, v.ad, v.wd, v.ack, v.rd);
      #1;
      chk($sformatf("v%0d_memReq", i), 16'(bus.memReq), 16'(v.e_req));
      chk($sformatf("v%0d_memWe", i), 16'(bus.memWe), 16'(v.e_we));
      chk($sformatf("v%0d_Rin", i), 16'(bus.Rin), 16'(v.e_rin));
      chk($sformatf("v%0d_done", i), 16'(bus.done), 16'(v.e_done));
      chk($sformatf("v%0d_stall", i), 16'(bus.stall), 16'(v.e_stall));
      chk($sformatf("v%0d_memAddr", i), 16'(bus.memAddr), 16'(v.e_addr));
      chk($sformatf("v%0d_memWData", i), 16'(bus.memWData), 16'(v.e_wd));
      chk($sformatf("v%0d_regSel", i), 16'(bus.regSel), 16'(v.e_rs));
      chk($sformatf("v%0d_rData", i), 16'(bus.rData), 16'(v.e_rd));
      chk($sformatf("v%0d_error", i), 16'(bus.error), 16'h0);
    end

    // asynchronous reset while in REQ
    @(negedge clk);
    drive(1, 0, 6, 8'h42, 8'h00, 0, 8'h00);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    #1 chk("ar_memReq_pre", 16'(bus.memReq), 16'h1);
    #2 rst = 1'b0;
    #1;
    chk("ar_memReq", 16'(bus.memReq), 16'h0);
    chk("ar_stall", 16'(bus.stall), 16'h0);
    chk("ar_Rin", 16'(bus.Rin), 16'h0);
    chk("ar_done", 16'(bus.done), 16'h0);
    chk("ar_memAddr", 16'(bus.memAddr), 16'h0);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 8'h33);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    #1 chk("ar_hold_Rin", 16'(bus.Rin), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 2, 8'h81, 8'h18, 0, 8'h00);
    #1 chk("ar_new_stall", 16'(bus.stall), 16'h1);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 8'h00);
    #1;
    chk("ar_new_memWe", 16'(bus.memWe), 16'h1);
    chk("ar_new_memAddr", 16'(bus.memAddr), 16'h81);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    #1;
    chk("ar_new_done", 16'(bus.done), 16'h1);
    chk("ar_new_Rin", 16'(bus.Rin), 16'h0);
    @(negedge clk);
    #1 chk("ar_new_idle_done", 16'(bus.done), 16'h0);

`ifdef MEM_TIMEOUT_EN
    // no ack for 15 REQ cycles -> abort
    @(negedge clk);
    drive(1, 0, 4, 8'h20, 8'h00, 0, 8'h00);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("to_req%0d", i), 16'(bus.memReq), 16'h1);
      chk($sformatf("to_err%0d", i), 16'(bus.error), 16'h0);
      @(negedge clk);
    end
    #1;
    chk("to_done", 16'(bus.done), 16'h1);
    chk("to_error", 16'(bus.error), 16'h1);
    chk("to_memReq", 16'(bus.memReq), 16'h0);
    chk("to_Rin", 16'(bus.Rin), 16'h0);
    @(negedge clk);
    #1 chk("to_error_clr", 16'(bus.error), 16'h0);

    // ack on the 15th REQ cycle completes normally
    @(negedge clk);
    drive(1, 0, 4, 8'h21, 8'h00, 0, 8'h00);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 14; i++) begin
      #1 chk($sformatf("ta_req%0d", i), 16'(bus.memReq), 16'h1);
      @(negedge clk);
    end
    drive(0, 0, 0, 8'h00, 8'h00, 1, 8'h5A);
    #1 chk("ta_req15", 16'(bus.memReq), 16'h1);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    #1;
    chk("ta_Rin", 16'(bus.Rin), 16'h1);
    chk("ta_rData", 16'(bus.rData), 16'h5A);
    @(negedge clk);
    #1;
    chk("ta_done", 16'(bus.done), 16'h1);
    chk("ta_error", 16'(bus.error), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
